// File: rtl/median_pkg.sv
// Shared sizes, rank constants and pixel type for the streaming median filter.
package median_pkg;
   localparam int DATA_W  = 8;
   localparam int MAX_IMG = 511;
   localparam int SIZE_W  = 9;
   localparam int WIN_MAX = 7;
   localparam int RANK_3  = 4;
   localparam int RANK_5  = 12;
   localparam int RANK_7  = 24;

   typedef logic [DATA_W-1:0] pixel_t;
endpackage

// File: rtl/median_rank.sv
// Combinational rank select: returns the element of rank RANK among K*K pixels.
module median_rank
   import median_pkg::*;
#(
   parameter int K    = 3,
   parameter int RANK = (K*K-1)/2
) (
   input  logic [K*K*DATA_W-1:0] pix_i,
   output pixel_t                med_o
);
   localparam int NUM = K*K;
   localparam int CW  = $clog2(NUM);
   localparam logic [CW-1:0] RANK_C = CW'(RANK);

   logic [CW-1:0] cnt;

   // Equal values are tie-broken by index so that every element gets a unique rank.
   always_comb begin
      med_o = '0;
      cnt   = '0;
      for (int i = 0; i < NUM; i++) begin
         cnt = '0;
         for (int j = 0; j < NUM; j++) begin
            if ((pix_i[j*DATA_W +: DATA_W] < pix_i[i*DATA_W +: DATA_W]) ||
                ((pix_i[j*DATA_W +: DATA_W] == pix_i[i*DATA_W +: DATA_W]) && (j < i)))
               cnt = cnt + 1'b1;
         end
         if (cnt == RANK_C)
            med_o = pix_i[i*DATA_W +: DATA_W];
      end
   end
endmodule

// File: rtl/median_filter.sv
// Streaming 3x3/5x5/7x7 median filter sharing one 7x7 window fed by six line buffers.
module median_filter
   import median_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   input  logic              s_axis_tready,
   input  logic [SIZE_W-1:0] IMG_SIZE_I,
   output logic [DATA_W-1:0] data_root_o,
   output logic              data_root_valid_o,
   output logic [DATA_W-1:0] m_3x3_o,
   output logic              m_3x3_valid_o,
   output logic [DATA_W-1:0] m_5x5_o,
   output logic              m_5x5_valid_o,
   output logic [DATA_W-1:0] m_7x7_o,
   output logic              m_7x7_valid_o
);
   logic              accept;
   logic [SIZE_W-1:0] row, col, n_frame, n_cur;
   logic              last_col, last_row;
   logic              v3, v5, v7;
   pixel_t            lb      [WIN_MAX-1][MAX_IMG];
   pixel_t            col_pix [WIN_MAX];
   pixel_t            win     [WIN_MAX][WIN_MAX];
   logic [9*DATA_W-1:0]  w3;
   logic [25*DATA_W-1:0] w5;
   logic [49*DATA_W-1:0] w7;
   pixel_t            med3, med5, med7;

   assign accept = s_axis_tvalid && s_axis_tready;

   // Frame size is taken live on pixel (0,0) and held for the rest of the frame.
   always_comb begin
      n_cur    = (row == '0 && col == '0) ? IMG_SIZE_I : n_frame;
      last_col = (col == n_cur - 1'b1) || (col == SIZE_W'(MAX_IMG-1));
      last_row = (row == n_cur - 1'b1) || (row == SIZE_W'(MAX_IMG-1));
   end

   // Incoming column, top (six rows up) to bottom (the new pixel).
   always_comb begin
      for (int j = 0; j < WIN_MAX-1; j++)
         col_pix[WIN_MAX-2-j] = lb[j][col];
      col_pix[WIN_MAX-1] = s_axis_tdata;
   end

   // Line buffers form a vertical shift chain per column: lb[0] is the previous row.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb[0][col] <= s_axis_tdata;
         for (int j = 1; j < WIN_MAX-1; j++)
            lb[j][col] <= lb[j-1][col];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row               <= '0;
         col               <= '0;
         n_frame           <= '0;
         v3                <= 1'b0;
         v5                <= 1'b0;
         v7                <= 1'b0;
         data_root_o       <= '0;
         data_root_valid_o <= 1'b0;
         for (int r = 0; r < WIN_MAX; r++)
            for (int c = 0; c < WIN_MAX; c++)
               win[r][c] <= '0;
      end else begin
         data_root_valid_o <= accept;
         v3 <= accept && (row >= SIZE_W'(2)) && (col >= SIZE_W'(2));
         v5 <= accept && (row >= SIZE_W'(4)) && (col >= SIZE_W'(4));
         v7 <= accept && (row >= SIZE_W'(6)) && (col >= SIZE_W'(6));
         if (accept) begin
            data_root_o <= s_axis_tdata;
            n_frame     <= n_cur;
            for (int r = 0; r < WIN_MAX; r++) begin
               for (int c = 0; c < WIN_MAX-1; c++)
                  win[r][c] <= win[r][c+1];
               win[r][WIN_MAX-1] <= col_pix[r];
            end
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Each kernel uses the bottom-right corner of the shared window.
   always_comb begin
      w3 = '0;
      w5 = '0;
      w7 = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w3[(r*3+c)*DATA_W +: DATA_W] = win[4+r][4+c];
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            w5[(r*5+c)*DATA_W +: DATA_W] = win[2+r][2+c];
      for (int r = 0; r < 7; r++)
         for (int c = 0; c < 7; c++)
            w7[(r*7+c)*DATA_W +: DATA_W] = win[r][c];
   end

   median_rank #(.K(3), .RANK(RANK_3)) u_rank3 (.pix_i(w3), .med_o(med3));
   median_rank #(.K(5), .RANK(RANK_5)) u_rank5 (.pix_i(w5), .med_o(med5));
   median_rank #(.K(7), .RANK(RANK_7)) u_rank7 (.pix_i(w7), .med_o(med7));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_3x3_o       <= '0;
         m_5x5_o       <= '0;
         m_7x7_o       <= '0;
         m_3x3_valid_o <= 1'b0;
         m_5x5_valid_o <= 1'b0;
         m_7x7_valid_o <= 1'b0;
      end else begin
         m_3x3_valid_o <= v3;
         m_5x5_valid_o <= v5;
         m_7x7_valid_o <= v7;
         if (v3) m_3x3_o <= med3;
         if (v5) m_5x5_o <= med5;
         if (v7) m_7x7_o <= med7;
      end
   end
endmodule

// File: tb/tb_median_filter.sv
// Randomized bench for median_filter with a sorting reference model and timed scoreboard.
module tb_median_filter;
   import median_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic [SIZE_W-1:0] IMG_SIZE_I;
   logic [DATA_W-1:0] data_root_o, m_3x3_o, m_5x5_o, m_7x7_o;
   logic              data_root_valid_o, m_3x3_valid_o, m_5x5_valid_o, m_7x7_valid_o;

   median_filter dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .IMG_SIZE_I(IMG_SIZE_I),
      .data_root_o(data_root_o), .data_root_valid_o(data_root_valid_o),
      .m_3x3_o(m_3x3_o), .m_3x3_valid_o(m_3x3_valid_o),
      .m_5x5_o(m_5x5_o), .m_5x5_valid_o(m_5x5_valid_o),
      .m_7x7_o(m_7x7_o), .m_7x7_valid_o(m_7x7_valid_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     s;
      int     val;
      longint due;
   } exp_t;

   exp_t   q[$];
   longint cyc = 0;
   int     checks = 0;
   int     failures = 0;
   int     img [32][32];
   int     mrow = 0, mcol = 0, mn = 9;
   int     seen_cnt [4];
   int     first_v  [4];
   int     last_v   [4];
   int     nonzero_cnt;
   bit     ev [4];
   int     ed [4];
   int     av [4];
   int     ad [4];
   string  names [4] = '{"root", "m3x3", "m5x5", "m7x7"};

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Median of a k x k neighbourhood ending at (r,c): sort and pick the middle.
   function automatic int model_median(input int k, input int r, input int c);
      int w[$];
      for (int dr = 0; dr < k; dr++)
         for (int dc = 0; dc < k; dc++)
            w.push_back(img[r-dr][c-dc]);
      w.sort();
      return w[(k*k-1)/2];
   endfunction

   task automatic model_accept(input int d);
      if (mrow == 0 && mcol == 0) mn = int'(IMG_SIZE_I);
      if (mrow < 32 && mcol < 32) img[mrow][mcol] = d;
      q.push_back('{0, d, cyc});
      for (int ki = 1; ki <= 3; ki++) begin
         int k;
         k = 2*ki + 1;
         if (mrow >= k-1 && mcol >= k-1 && mrow < 32 && mcol < 32)
            q.push_back('{ki, model_median(k, mrow, mcol), cyc + 1});
      end
      if (mcol == mn-1) begin
         mcol = 0;
         mrow = (mrow == mn-1) ? 0 : mrow + 1;
      end else begin
         mcol = mcol + 1;
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (!rst && s_axis_tvalid && s_axis_tready)
         model_accept(int'(s_axis_tdata));
   end

   // Every output strobe and its data is checked each cycle against the due scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         for (int s = 0; s < 4; s++) begin ev[s] = 1'b0; ed[s] = 0; end
         while (q.size() > 0 && q[0].due <= cyc) begin
            if (q[0].due == cyc) begin
               ev[q[0].s] = 1'b1;
               ed[q[0].s] = q[0].val;
            end
            void'(q.pop_front());
         end
         av[0] = int'(data_root_valid_o); ad[0] = int'(data_root_o);
         av[1] = int'(m_3x3_valid_o);     ad[1] = int'(m_3x3_o);
         av[2] = int'(m_5x5_valid_o);     ad[2] = int'(m_5x5_o);
         av[3] = int'(m_7x7_valid_o);     ad[3] = int'(m_7x7_o);
         for (int s = 0; s < 4; s++) begin
            checkOutput({names[s], "_valid"}, av[s], int'(ev[s]));
            if (ev[s] && av[s] == 1) checkOutput(names[s], ad[s], ed[s]);
            if (av[s] == 1) begin
               if (seen_cnt[s] == 0) first_v[s] = ad[s];
               last_v[s] = ad[s];
               seen_cnt[s]++;
               if (s > 0 && ad[s] != 0) nonzero_cnt++;
            end
         end
      end
   end

   task automatic reset_stats();
      for (int s = 0; s < 4; s++) begin
         seen_cnt[s] = 0; first_v[s] = -1; last_v[s] = -1;
      end
      nonzero_cnt = 0;
   endtask

   function automatic int pix(input int kind, input int i, input int n);
      case (kind)
         0:       return i;
         1:       return 8'h55;
         2:       return (i == 4*n + 4) ? 255 : 0;
         3:       return 120 - i;
         default: return int'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // Sends one frame; gappy inserts stalls and scrambles IMG_SIZE_I after pixel 0.
   task automatic applyStimulus(input int kind, input int n, input bit gappy, input int stop_after);
      IMG_SIZE_I = SIZE_W'(n);
      for (int i = 0; i < n*n; i++) begin
         if (stop_after >= 0 && i == stop_after) return;
         if (gappy) begin
            for (int g = 0; g < 4; g++) begin
               if ($urandom_range(0, 2) != 0) break;
               s_axis_tvalid = 1'($urandom_range(0, 1));
               s_axis_tready = s_axis_tvalid ? 1'b0 : 1'($urandom_range(0, 1));
               s_axis_tdata  = 8'($urandom_range(0, 255));
               @(posedge clk); #1;
            end
         end
         s_axis_tdata  = 8'(pix(kind, i, n));
         s_axis_tvalid = 1'b1;
         s_axis_tready = 1'b1;
         @(posedge clk); #1;
         if (gappy && i == 0) IMG_SIZE_I = SIZE_W'($urandom_range(7, 31));
      end
   endtask

   task automatic check_ramp9(input string tag);
      checkOutput({tag, "_root_cnt"}, seen_cnt[0], 81);
      checkOutput({tag, "_m3_cnt"},   seen_cnt[1], 49);
      checkOutput({tag, "_m3_first"}, first_v[1],  10);
      checkOutput({tag, "_m3_last"},  last_v[1],   70);
      checkOutput({tag, "_m5_cnt"},   seen_cnt[2], 25);
      checkOutput({tag, "_m5_first"}, first_v[2],  20);
      checkOutput({tag, "_m5_last"},  last_v[2],   60);
      checkOutput({tag, "_m7_cnt"},   seen_cnt[3], 9);
      checkOutput({tag, "_m7_first"}, first_v[3],  30);
      checkOutput({tag, "_m7_last"},  last_v[3],   50);
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_root"},    int'(data_root_o), 0);
      checkOutput({tag, "_root_v"},  int'(data_root_valid_o), 0);
      checkOutput({tag, "_m3"},      int'(m_3x3_o), 0);
      checkOutput({tag, "_m3_v"},    int'(m_3x3_valid_o), 0);
      checkOutput({tag, "_m5"},      int'(m_5x5_o), 0);
      checkOutput({tag, "_m5_v"},    int'(m_5x5_valid_o), 0);
      checkOutput({tag, "_m7"},      int'(m_7x7_o), 0);
      checkOutput({tag, "_m7_v"},    int'(m_7x7_valid_o), 0);
   endtask

   initial begin
      rst           = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tready = 1'b0;
      IMG_SIZE_I    = SIZE_W'(9);
      reset_stats();
      #2;
      check_all_zero("reset");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] ramp N=9");
      reset_stats();
      applyStimulus(0, 9, 1'b0, -1);
      idle(6);
      check_ramp9("ramp");

      $display("[TB] constant N=9");
      reset_stats();
      applyStimulus(1, 9, 1'b0, -1);
      idle(6);
      checkOutput("const_root_cnt", seen_cnt[0], 81);
      checkOutput("const_med_cnt", seen_cnt[1] + seen_cnt[2] + seen_cnt[3], 83);
      checkOutput("const_m7_last", last_v[3], 8'h55);

      $display("[TB] impulse N=9");
      reset_stats();
      applyStimulus(2, 9, 1'b0, -1);
      idle(6);
      checkOutput("impulse_nonzero", nonzero_cnt, 0);
      checkOutput("impulse_m3_cnt", seen_cnt[1], 49);

      $display("[TB] gappy ramp N=9");
      reset_stats();
      applyStimulus(0, 9, 1'b1, -1);
      idle(6);
      check_ramp9("gappy");

      $display("[TB] back-to-back ramp N=9 then reversed N=11");
      reset_stats();
      applyStimulus(0, 9, 1'b0, -1);
      applyStimulus(3, 11, 1'b0, -1);
      idle(6);
      checkOutput("b2b_m3_cnt", seen_cnt[1], 49 + 81);
      checkOutput("b2b_m5_cnt", seen_cnt[2], 25 + 49);
      checkOutput("b2b_m7_cnt", seen_cnt[3], 9 + 25);
      checkOutput("b2b_m3_last", last_v[1], 12);
      checkOutput("b2b_m5_last", last_v[2], 24);
      checkOutput("b2b_m7_last", last_v[3], 36);

      $display("[TB] random pixels, N=7 and gappy N=12");
      reset_stats();
      applyStimulus(4, 7, 1'b0, -1);
      idle(6);
      checkOutput("n7_m3_cnt", seen_cnt[1], 25);
      checkOutput("n7_m7_cnt", seen_cnt[3], 1);
      applyStimulus(4, 12, 1'b1, -1);
      idle(6);

      $display("[TB] undersized ramp N=5");
      reset_stats();
      applyStimulus(0, 5, 1'b0, -1);
      idle(6);
      checkOutput("n5_m3_cnt",   seen_cnt[1], 9);
      checkOutput("n5_m3_first", first_v[1],  6);
      checkOutput("n5_m3_last",  last_v[1],   18);
      checkOutput("n5_m5_cnt",   seen_cnt[2], 1);
      checkOutput("n5_m5_val",   last_v[2],   12);
      checkOutput("n5_m7_cnt",   seen_cnt[3], 0);

      $display("[TB] reset mid-frame");
      applyStimulus(0, 9, 1'b0, 5*9 + 3);
      #2;
      rst           = 1'b1;
      s_axis_tvalid = 1'b0;
      #1;
      check_all_zero("midreset");
      q.delete();
      mrow = 0;
      mcol = 0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      reset_stats();
      applyStimulus(0, 9, 1'b0, -1);
      idle(6);
      check_ramp9("postreset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
